// File: rtl/store_buffer.sv
// store_buffer: in-order posted-write FIFO of byte-masked word entries with a
// combinational load lookup that reports full-coverage hits or partial-overlap conflicts.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [1:0]        st_size,
   output logic              st_misaligned,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [1:0]        ld_size,
   output logic              ld_hit,
   output logic              ld_conflict,
   output logic [31:0]       ld_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_data,
   output logic [3:0]        mem_req_be,
   output logic [CNT_W-1:0]  count,
   output logic              empty
);
   localparam int PW = $clog2(DEPTH);

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
      return size == 2'b00 ? 4'b0001 << a : size == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
   endfunction

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
      return size == 2'b00 || (size == 2'b01 && !a[0]) || (size == 2'b10 && a == 2'b00);
   endfunction

   logic [ADDR_W-3:0] e_addr [DEPTH];
   logic [31:0]       e_data [DEPTH];
   logic [3:0]        e_be   [DEPTH];
   logic [DEPTH-1:0]  e_valid;
   logic [PW-1:0]     head, tail, idx;
   logic [31:0]       st_lane, y_data;
   logic [3:0]        ld_mask;
   logic              st_ok, push, pop, y_cover, any_ov, ov, ld_act;

   assign st_ok    = is_aligned(st_size, st_addr[1:0]);
   assign st_lane  = st_size == 2'b00 ? {24'b0, st_data[7:0]} << {st_addr[1:0], 3'b000} :
                     st_size == 2'b01 ? {16'b0, st_data[15:0]} << {st_addr[1], 4'b0000} : st_data;
   assign st_ready = count < CNT_W'(DEPTH);
   assign push     = st_valid & st_ready & st_ok;
   assign empty    = reset | (count == '0);
   assign mem_req_valid = !empty;
   assign pop      = mem_req_valid & mem_req_ready;
   assign mem_req_addr  = {e_addr[head], 2'b00};
   assign mem_req_data  = e_data[head];
   assign mem_req_be    = e_be[head];

   always_ff @(posedge clk) begin
      if (reset) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         e_valid       <= '0;
         st_misaligned <= 1'b0;
      end else begin
         st_misaligned <= st_valid & st_ready & !st_ok;
         if (push) begin
            e_addr[tail]  <= st_addr[ADDR_W-1:2];
            e_data[tail]  <= st_lane;
            e_be[tail]    <= lane_be(st_size, st_addr[1:0]);
            e_valid[tail] <= 1'b1;
            tail          <= tail + PW'(1);
         end
         if (pop) begin
            e_valid[head] <= 1'b0;
            head          <= head + PW'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Walk oldest to youngest so the last overlapping entry seen is the youngest.
   always_comb begin
      ld_mask = lane_be(ld_size, ld_addr[1:0]);
      idx     = '0;
      ov      = 1'b0;
      any_ov  = 1'b0;
      y_cover = 1'b0;
      y_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         ov  = e_valid[idx] && e_addr[idx] == ld_addr[ADDR_W-1:2] && (e_be[idx] & ld_mask) != 4'b0;
         if (ov) begin
            any_ov  = 1'b1;
            y_cover = (e_be[idx] & ld_mask) == ld_mask;
            y_data  = e_data[idx];
         end
      end
      ld_act      = ld_valid & !reset & is_aligned(ld_size, ld_addr[1:0]);
      ld_hit      = ld_act & y_cover;
      ld_conflict = ld_act & any_ov & !y_cover;
      ld_data     = ld_hit ? y_data : 32'b0;
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic checked every cycle
// against a queue-based model of the store buffer.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          st_valid, st_ready, st_misaligned;
   logic [AW-1:0] st_addr, ld_addr, mem_req_addr;
   logic [31:0]   st_data, ld_data, mem_req_data;
   logic [1:0]    st_size, ld_size;
   logic          ld_valid, ld_hit, ld_conflict;
   logic          mem_req_valid, mem_req_ready, empty;
   logic [3:0]    mem_req_be;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .st_size(st_size), .st_misaligned(st_misaligned),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
      .ld_hit(ld_hit), .ld_conflict(ld_conflict), .ld_data(ld_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
      .count(count), .empty(empty)
   );

   typedef struct packed {
      logic [AW-3:0] wa;
      logic [31:0]   d;
      logic [3:0]    be;
   } ent_t;

   ent_t q[$];
   logic m_mis = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic ok_align(input logic [1:0] sz, input logic [AW-1:0] a);
      return sz != 2'b11 && (int'(a[1:0]) % (1 << sz)) == 0;
   endfunction

   // Bytes k of the access land in lanes off+k of the word.
   function automatic ent_t mk(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] sz);
      ent_t e;
      int   n, off;
      n    = 1 << sz;
      off  = sz == 2'b10 ? 0 : int'(a[1:0]);
      e.wa = a[AW-1:2];
      e.be = '0;
      e.d  = '0;
      for (int k = 0; k < n; k++) begin
         e.be[off+k]       = 1'b1;
         e.d[8*(off+k)+:8] = d[8*k+:8];
      end
      return e;
   endfunction

   always @(posedge clk) begin
      int   sz;
      logic pu, po;
      if (reset) begin
         q.delete();
         m_mis = 1'b0;
      end else begin
         sz    = q.size();
         po    = sz != 0 && mem_req_ready;
         pu    = st_valid && sz < DEPTH && ok_align(st_size, st_addr);
         m_mis = st_valid && sz < DEPTH && !ok_align(st_size, st_addr);
         if (po) void'(q.pop_front());
         if (pu) q.push_back(mk(st_addr, st_data, st_size));
      end
   end

   always @(negedge clk) begin
      ent_t        lm;
      logic        eh, ec;
      logic [31:0] ed;
      eh = 1'b0;
      ec = 1'b0;
      ed = '0;
      if (!reset && ld_valid && ok_align(ld_size, ld_addr)) begin
         lm = mk(ld_addr, 32'h0, ld_size);
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wa == lm.wa && (q[i].be & lm.be) != 4'b0) begin
               eh = (q[i].be & lm.be) == lm.be;
               ec = !eh;
               ed = eh ? q[i].d : 32'h0;
               break;
            end
         end
      end
      chk("ld_hit", 32'(ld_hit), 32'(eh));
      chk("ld_conflict", 32'(ld_conflict), 32'(ec));
      chk("ld_data", ld_data, ed);
      if (reset) begin
         chk("rst_mem_valid", 32'(mem_req_valid), 32'h0);
         chk("rst_empty", 32'(empty), 32'h1);
      end else begin
         chk("count", 32'(count), 32'(q.size()));
         chk("empty", 32'(empty), 32'(q.size() == 0));
         chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
         chk("mem_valid", 32'(mem_req_valid), 32'(q.size() != 0));
         chk("st_misaligned", 32'(st_misaligned), 32'(m_mis));
         if (q.size() != 0) begin
            chk("mem_addr", mem_req_addr, {q[0].wa, 2'b00});
            chk("mem_data", mem_req_data, q[0].d);
            chk("mem_be", 32'(mem_req_be), 32'(q[0].be));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      st_valid = v;
      st_addr  = a;
      st_data  = d;
      st_size  = sz;
   endtask

   task automatic ld(input logic v, input logic [31:0] a, input logic [1:0] sz);
      ld_valid = v;
      ld_addr  = a;
      ld_size  = sz;
      #1;
   endtask

   initial begin
      st(0, 0, 0, 0);
      ld_valid = 0; ld_addr = 0; ld_size = 0;
      mem_req_ready = 0;
      tick(2);
      reset = 0;
      chk("init_count", 32'(count), 32'h0);
      chk("init_empty", 32'(empty), 32'h1);
      chk("init_valid", 32'(mem_req_valid), 32'h0);
      // byte store lands in lane 1 and is held while memory stalls
      st(1, 32'h101, 32'hAB, 2'b00);
      tick(1);
      st_valid = 0;
      for (int i = 0; i < 4; i++) begin
         chk("sb_count", 32'(count), 32'h1);
         chk("sb_valid", 32'(mem_req_valid), 32'h1);
         chk("sb_addr", mem_req_addr, 32'h100);
         chk("sb_be", 32'(mem_req_be), 32'h2);
         chk("sb_data", mem_req_data, 32'h0000AB00);
         tick(1);
      end
      mem_req_ready = 1;
      tick(1);
      mem_req_ready = 0;
      chk("sb_drained", 32'(count), 32'h0);
      // fill to DEPTH, fifth store waits until a pop frees a slot
      for (int i = 0; i < 4; i++) begin
         st(1, 32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
         tick(1);
      end
      chk("full_count", 32'(count), 32'h4);
      chk("full_ready", 32'(st_ready), 32'h0);
      st(1, 32'h410, 32'hA4, 2'b10);
      mem_req_ready = 1;
      tick(1);
      mem_req_ready = 0;
      chk("full_pop", 32'(count), 32'h3);
      chk("full_ready2", 32'(st_ready), 32'h1);
      tick(1);
      st_valid = 0;
      chk("full_refill", 32'(count), 32'h4);
      mem_req_ready = 1;
      tick(4);
      mem_req_ready = 0;
      // load forwarding and conflict
      st(1, 32'h200, 32'h11223344, 2'b10);
      tick(1);
      st(1, 32'h202, 32'hBEEF, 2'b01);
      tick(1);
      st_valid = 0;
      ld(1, 32'h202, 2'b01);
      chk("lh_hit", 32'(ld_hit), 32'h1);
      chk("lh_conf", 32'(ld_conflict), 32'h0);
      chk("lh_data", ld_data, 32'hBEEF0000);
      ld(1, 32'h200, 2'b10);
      chk("lw_conf", 32'(ld_conflict), 32'h1);
      chk("lw_hit", 32'(ld_hit), 32'h0);
      ld(1, 32'h200, 2'b00);
      chk("lb_hit", 32'(ld_hit), 32'h1);
      chk("lb_data", ld_data, 32'h11223344);
      ld(1, 32'h201, 2'b01);
      chk("lmis_hit", 32'(ld_hit), 32'h0);
      chk("lmis_conf", 32'(ld_conflict), 32'h0);
      ld(0, 32'h200, 2'b10);
      mem_req_ready = 1;
      tick(2);
      mem_req_ready = 0;
      // misaligned store is dropped with a one-cycle flag
      st(1, 32'h103, 32'h1234, 2'b01);
      tick(1);
      st_valid = 0;
      chk("mis_flag", 32'(st_misaligned), 32'h1);
      chk("mis_count", 32'(count), 32'h0);
      chk("mis_valid", 32'(mem_req_valid), 32'h0);
      tick(1);
      chk("mis_clear", 32'(st_misaligned), 32'h0);
      // reset while draining
      for (int i = 0; i < 3; i++) begin
         st(1, 32'h500 + 32'(4 * i), 32'hC0 + 32'(i), 2'b10);
         tick(1);
      end
      st_valid = 0;
      mem_req_ready = 1;
      reset = 1;
      ld(1, 32'h500, 2'b10);
      chk("rstd_valid", 32'(mem_req_valid), 32'h0);
      chk("rstd_empty", 32'(empty), 32'h1);
      chk("rstd_hit", 32'(ld_hit), 32'h0);
      tick(1);
      reset = 0;
      ld_valid = 0;
      chk("rstd_count", 32'(count), 32'h0);
      chk("rstd_valid2", 32'(mem_req_valid), 32'h0);
      chk("rstd_empty2", 32'(empty), 32'h1);
      tick(1);
      chk("rstd_count2", 32'(count), 32'h0);
      mem_req_ready = 0;
      // steady push+pop at count 2 across pointer wrap
      for (int i = 0; i < 2; i++) begin
         st(1, 32'h600 + 32'(4 * i), 32'hD0 + 32'(i), 2'b10);
         tick(1);
      end
      mem_req_ready = 1;
      for (int i = 0; i < 2 * DEPTH; i++) begin
         st(1, 32'h608 + 32'(4 * i), 32'hE0 + 32'(i), 2'b10);
         tick(1);
         chk("wrap_count", 32'(count), 32'h2);
      end
      st_valid = 0;
      tick(2);
      mem_req_ready = 0;
      // random traffic in a narrow window to force overlaps
      for (int i = 0; i < 2000; i++) begin
         st(1'($urandom_range(0, 1)), 32'h300 + $urandom_range(0, 11), $urandom, 2'($urandom_range(0, 3)));
         ld_valid = 1'($urandom_range(0, 1));
         ld_addr = 32'h300 + $urandom_range(0, 11);
         ld_size = 2'($urandom_range(0, 2));
         mem_req_ready = $urandom_range(0, 2) == 0;
         reset = $urandom_range(0, 199) == 0;
         tick(1);
      end
      reset = 0;
      st_valid = 0;
      ld_valid = 0;
      mem_req_ready = 1;
      tick(DEPTH + 1);
      chk("final_empty", 32'(empty), 32'h1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
